hxd_fetch_queue: RTL and testbench

Parametrised instruction-fetch unit with a prefetch queue. It is the next-generation replacement for the single-register IFU/pipe_ifu pair in the hxd32 core. It issues sequential IRAM reads ahead of decode and buffers returned words with their PCs in a DEPTH-entry FIFO. It presents them to decode over a valid/ready handshake, squashes in-flight and buffered words on a redirect, and latches a sticky fault on an all-zero-low-half instruction word.

---
 rtl/hxd_fetch_queue_if.sv | 35 +++
 rtl/hxd_fetch_queue.sv | 109 ++++++++++
 tb/tb_hxd_fetch_queue.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hxd_fetch_queue_if.sv
// Fetch-queue bus bundle: IRAM read port, redirect input, decode handshake and fault report.
// Field names carry the direction as seen from the fetch unit (master side).
interface hxd_fetch_queue_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            iram_rd_en_o;
    logic [XLEN-1:0] iram_rd_addr_o;
    logic [XLEN-1:0] iram_rd_data_i;
    logic            redirect_en_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            inst_valid_o;
    logic            inst_ready_i;
    logic [XLEN-1:0] inst_data_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            fault_o;
    logic [XLEN-1:0] fault_pc_o;

    modport master (
        output iram_rd_en_o, iram_rd_addr_o,
        input  iram_rd_data_i,
        input  redirect_en_i, redirect_pc_i,
        output inst_valid_o, inst_data_o, inst_pc_o,
        input  inst_ready_i,
        output fault_o, fault_pc_o
    );

    modport slave (
        input  iram_rd_en_o, iram_rd_addr_o,
        output iram_rd_data_i,
        output redirect_en_i, redirect_pc_i,
        input  inst_valid_o, inst_data_o, inst_pc_o,
        output inst_ready_i,
        input  fault_o, fault_pc_o
    );
endinterface

// File: rtl/hxd_fetch_queue.sv
// Instruction fetch unit: issues sequential IRAM reads ahead of decode into a DEPTH-entry
// {pc, data} FIFO, flushes on redirect and latches a sticky fault on a zero-low-half word.
module hxd_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013)
) (
    input logic               clk_i,
    input logic               rst_n_i,
    hxd_fetch_queue_if.master fq
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DepthOcc = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rd_pc_q;
    logic            inflight_q;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic [XLEN-1:0] head_pc, head_data;
    logic            not_empty, head_faulting, redirect, valid, pop, push, issue;
    logic [CW:0]     occ;

    always_comb begin
        head_pc       = pc_mem[rd_ptr_q];
        head_data     = data_mem[rd_ptr_q];
        not_empty     = (count_q != '0);
        head_faulting = not_empty & (head_data[15:0] == 16'h0000);
        // Once faulted the unit is frozen; redirects no longer apply.
        redirect      = fq.redirect_en_i & ~fault_q;
        valid         = rst_n_i & not_empty & ~fq.redirect_en_i & ~fault_q & ~head_faulting;
        pop           = valid & fq.inst_ready_i;
        // The read returning this cycle is the squashed one when a redirect arrives now.
        push          = inflight_q & ~redirect;
        occ           = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
        issue         = rst_n_i & ~fq.redirect_en_i & ~fault_q & (occ < DepthOcc);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        if (redirect) begin
            fetch_pc_d = fq.redirect_pc_i & ~XLEN'(3);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (!fault_q && head_faulting && !fq.redirect_en_i) begin
            fault_d    = 1'b1;
            fault_pc_d = head_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fetch_pc_q <= RESET_PC;
            rd_pc_q    <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (issue) begin
                rd_pc_q <= fetch_pc_q;
            end
            inflight_q <= issue;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && push) begin
            pc_mem[wr_ptr_q]   <= rd_pc_q;
            data_mem[wr_ptr_q] <= fq.iram_rd_data_i;
        end
    end

    assign fq.iram_rd_en_o   = issue;
    assign fq.iram_rd_addr_o = rst_n_i ? fetch_pc_q : RESET_PC;
    assign fq.inst_valid_o   = valid;
    assign fq.inst_data_o    = valid ? head_data : NOP_INST;
    assign fq.inst_pc_o      = head_pc;
    assign fq.fault_o        = fault_q;
    assign fq.fault_pc_o     = fault_pc_q;

    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push && !pop && count_q == CW'(DEPTH)))
        else $error("fetch queue push into full queue");
endmodule

// File: tb/tb_hxd_fetch_queue.sv
// Directed bench for hxd_fetch_queue: instance A (DEPTH=4, RESET_PC=0) and instance B
// (DEPTH=2, RESET_PC near the top of the address space) with 1-cycle IRAM models.
module tb_hxd_fetch_queue;
    localparam logic [31:0] Nop   = 32'h0000_0013;
    localparam logic [31:0] TopPc = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [31:0] rdata_a, rdata_b;
    logic [31:0] fault_addr;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    hxd_fetch_queue_if #(.XLEN(32)) ifa ();
    hxd_fetch_queue_if #(.XLEN(32)) ifb ();

    hxd_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP_INST(Nop)) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_a),
        .fq      (ifa.master)
    );

    hxd_fetch_queue #(.XLEN(32), .DEPTH(2), .RESET_PC(TopPc), .NOP_INST(Nop)) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_b),
        .fq      (ifb.master)
    );

    function automatic logic [31:0] iram_word(input logic [31:0] a);
        return (a == fault_addr) ? 32'h0 : (a | 32'h13);
    endfunction

    always_ff @(posedge clk) begin
        rdata_a <= iram_word(ifa.iram_rd_addr_o);
        rdata_b <= iram_word(ifb.iram_rd_addr_o);
    end
    assign ifa.iram_rd_data_i = rdata_a;
    assign ifb.iram_rd_data_i = rdata_b;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Leaves the bench settled inside cycle 0 of instance A.
    task automatic do_reset_a(input logic rdy);
        ifa.inst_ready_i  = rdy;
        ifa.redirect_en_i = 1'b0;
        rst_a = 1'b0;
        step();
        step();
        rst_a = 1'b1;
        settle();
    endtask

    task automatic test_reset();
        ifa.inst_ready_i = 1'b1;
        rst_a = 1'b0;
        step();
        step();
        settle();
        total++;
        if ({ifa.iram_rd_en_o, ifa.inst_valid_o, ifa.fault_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got en/v/f=%b%b%b want 000", ifa.iram_rd_en_o,
                     ifa.inst_valid_o, ifa.fault_o);
        end
        total++;
        if (ifa.iram_rd_addr_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr got %h want 00000000", ifa.iram_rd_addr_o);
        end
        total++;
        if (ifa.inst_data_o !== Nop) begin
            bad++;
            $display("FAIL reset_data got %h want %h", ifa.inst_data_o, Nop);
        end
        total++;
        if (ifa.fault_pc_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_fault_pc got %h want 00000000", ifa.fault_pc_o);
        end
        rst_a = 1'b1;
        settle();
        total++;
        if ({ifa.iram_rd_en_o, ifa.iram_rd_addr_o} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL cycle0_issue got en=%b addr=%h want en=1 addr=00000000",
                     ifa.iram_rd_en_o, ifa.iram_rd_addr_o);
        end
    endtask

    task automatic test_stream();
        do_reset_a(1'b1);
        total++;
        if (ifa.inst_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL stream_c0_valid got %b want 0", ifa.inst_valid_o);
        end
        step();
        settle();
        total++;
        if (ifa.inst_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL stream_c1_valid got %b want 0", ifa.inst_valid_o);
        end
        for (int i = 0; i < 64; i++) begin
            logic [31:0] e;
            step();
            settle();
            e = 32'(4 * i);
            total++;
            if ({ifa.inst_valid_o, ifa.inst_pc_o, ifa.inst_data_o} !== {1'b1, e, e | 32'h13})
            begin
                bad++;
                $display("FAIL stream[%0d] got v=%b pc=%h d=%h want v=1 pc=%h d=%h", i,
                         ifa.inst_valid_o, ifa.inst_pc_o, ifa.inst_data_o, e, e | 32'h13);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset_a(1'b0);
        for (int c = 0; c < 12; c++) begin
            if (c != 0) begin
                step();
                settle();
            end
            total++;
            if (ifa.iram_rd_en_o !== (c < 4) ||
                (c < 4 && ifa.iram_rd_addr_o !== 32'(4 * c))) begin
                bad++;
                $display("FAIL bp_issue[c%0d] got en=%b addr=%h want en=%b addr=%h", c,
                         ifa.iram_rd_en_o, ifa.iram_rd_addr_o, (c < 4), 32'(4 * c));
            end
            if (c >= 2) begin
                total++;
                if ({ifa.inst_valid_o, ifa.inst_pc_o} !== {1'b1, 32'h0}) begin
                    bad++;
                    $display("FAIL bp_hold[c%0d] got v=%b pc=%h want v=1 pc=00000000", c,
                             ifa.inst_valid_o, ifa.inst_pc_o);
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            step();
            ifa.inst_ready_i = 1'b1;
            settle();
            total++;
            if ({ifa.inst_valid_o, ifa.inst_pc_o} !== {1'b1, 32'(4 * k)}) begin
                bad++;
                $display("FAIL bp_drain[%0d] got v=%b pc=%h want v=1 pc=%h", k,
                         ifa.inst_valid_o, ifa.inst_pc_o, 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset_a(1'b0);
        for (int c = 1; c < 4; c++) begin
            step();
        end
        step();
        ifa.redirect_en_i = 1'b1;
        ifa.redirect_pc_i = 32'h100;
        ifa.inst_ready_i  = 1'b1;
        settle();
        total++;
        if ({ifa.inst_valid_o, ifa.iram_rd_en_o} !== 2'b00) begin
            bad++;
            $display("FAIL redir_cycle got v=%b en=%b want 00", ifa.inst_valid_o,
                     ifa.iram_rd_en_o);
        end
        step();
        ifa.redirect_en_i = 1'b0;
        settle();
        total++;
        if ({ifa.iram_rd_en_o, ifa.iram_rd_addr_o, ifa.inst_valid_o} !== {1'b1, 32'h100, 1'b0})
        begin
            bad++;
            $display("FAIL redir_target got en=%b addr=%h v=%b want en=1 addr=00000100 v=0",
                     ifa.iram_rd_en_o, ifa.iram_rd_addr_o, ifa.inst_valid_o);
        end
        step();
        settle();
        total++;
        if (ifa.inst_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL redir_gap got v=%b pc=%h want v=0", ifa.inst_valid_o, ifa.inst_pc_o);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            settle();
            total++;
            if ({ifa.inst_valid_o, ifa.inst_pc_o} !== {1'b1, 32'h100 + 32'(4 * k)}) begin
                bad++;
                $display("FAIL redir_seq[%0d] got v=%b pc=%h want v=1 pc=%h", k,
                         ifa.inst_valid_o, ifa.inst_pc_o, 32'h100 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_handshake();
        do_reset_a(1'b1);
        step();
        step();
        settle();
        total++;
        if ({ifa.inst_valid_o, ifa.inst_pc_o} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL rh_first got v=%b pc=%h want v=1 pc=00000000", ifa.inst_valid_o,
                     ifa.inst_pc_o);
        end
        step();
        ifa.redirect_en_i = 1'b1;
        ifa.redirect_pc_i = 32'h203;
        settle();
        total++;
        if ({ifa.inst_valid_o, ifa.inst_data_o} !== {1'b0, Nop}) begin
            bad++;
            $display("FAIL rh_suppress got v=%b d=%h want v=0 d=%h", ifa.inst_valid_o,
                     ifa.inst_data_o, Nop);
        end
        step();
        ifa.redirect_en_i = 1'b0;
        settle();
        total++;
        if ({ifa.iram_rd_en_o, ifa.iram_rd_addr_o} !== {1'b1, 32'h200}) begin
            bad++;
            $display("FAIL rh_issue got en=%b addr=%h want en=1 addr=00000200",
                     ifa.iram_rd_en_o, ifa.iram_rd_addr_o);
        end
        step();
        settle();
        total++;
        if (ifa.inst_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rh_gap got v=%b pc=%h want v=0", ifa.inst_valid_o, ifa.inst_pc_o);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            settle();
            total++;
            if ({ifa.inst_valid_o, ifa.inst_pc_o} !== {1'b1, 32'h200 + 32'(4 * k)}) begin
                bad++;
                $display("FAIL rh_seq[%0d] got v=%b pc=%h want v=1 pc=%h", k,
                         ifa.inst_valid_o, ifa.inst_pc_o, 32'h200 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_fault();
        fault_addr = 32'h10;
        do_reset_a(1'b1);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            settle();
            total++;
            if ({ifa.inst_valid_o, ifa.inst_pc_o} !== {1'b1, 32'(4 * k)}) begin
                bad++;
                $display("FAIL fault_pre[%0d] got v=%b pc=%h want v=1 pc=%h", k,
                         ifa.inst_valid_o, ifa.inst_pc_o, 32'(4 * k));
            end
        end
        step();
        settle();
        total++;
        if ({ifa.inst_valid_o, ifa.fault_o, ifa.iram_rd_en_o, ifa.iram_rd_addr_o} !==
            {1'b0, 1'b0, 1'b1, 32'h18}) begin
            bad++;
            $display("FAIL fault_head got v=%b f=%b en=%b addr=%h want v=0 f=0 en=1 addr=00000018",
                     ifa.inst_valid_o, ifa.fault_o, ifa.iram_rd_en_o, ifa.iram_rd_addr_o);
        end
        step();
        settle();
        total++;
        if ({ifa.fault_o, ifa.fault_pc_o, ifa.inst_valid_o, ifa.iram_rd_en_o} !==
            {1'b1, 32'h10, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL fault_rise got f=%b fpc=%h v=%b en=%b want f=1 fpc=00000010 v=0 en=0",
                     ifa.fault_o, ifa.fault_pc_o, ifa.inst_valid_o, ifa.iram_rd_en_o);
        end
        step();
        ifa.redirect_en_i = 1'b1;
        ifa.redirect_pc_i = 32'h300;
        settle();
        step();
        ifa.redirect_en_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                step();
            end
            settle();
            total++;
            if ({ifa.fault_o, ifa.fault_pc_o, ifa.inst_valid_o, ifa.iram_rd_en_o} !==
                {1'b1, 32'h10, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL fault_frozen[%0d] got f=%b fpc=%h v=%b en=%b addr=%h", k,
                         ifa.fault_o, ifa.fault_pc_o, ifa.inst_valid_o, ifa.iram_rd_en_o,
                         ifa.iram_rd_addr_o);
            end
        end
        rst_a = 1'b0;
        step();
        settle();
        total++;
        if ({ifa.fault_o, ifa.fault_pc_o} !== {1'b0, 32'h0}) begin
            bad++;
            $display("FAIL fault_clear got f=%b fpc=%h want f=0 fpc=00000000", ifa.fault_o,
                     ifa.fault_pc_o);
        end
        rst_a = 1'b1;
        fault_addr = 32'h1;
    endtask

    task automatic test_wrap();
        ifb.inst_ready_i = 1'b1;
        rst_b = 1'b0;
        step();
        step();
        rst_b = 1'b1;
        settle();
        total++;
        if ({ifb.iram_rd_en_o, ifb.iram_rd_addr_o} !== {1'b1, TopPc}) begin
            bad++;
            $display("FAIL wrap_c0 got en=%b addr=%h want en=1 addr=%h", ifb.iram_rd_en_o,
                     ifb.iram_rd_addr_o, TopPc);
        end
        step();
        step();
        settle();
        total++;
        if ({ifb.iram_rd_en_o, ifb.iram_rd_addr_o} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL wrap_addr got en=%b addr=%h want en=1 addr=00000000",
                     ifb.iram_rd_en_o, ifb.iram_rd_addr_o);
        end
        for (int i = 0; i < 10; i++) begin
            logic [31:0] e;
            if (i != 0) begin
                step();
                settle();
            end
            e = TopPc + 32'(4 * i);
            total++;
            if ({ifb.inst_valid_o, ifb.inst_pc_o} !== {1'b1, e}) begin
                bad++;
                $display("FAIL wrap_seq[%0d] got v=%b pc=%h want v=1 pc=%h", i,
                         ifb.inst_valid_o, ifb.inst_pc_o, e);
            end
        end
        step();
        rst_b = 1'b0;
        step();
        settle();
        total++;
        if ({ifb.iram_rd_en_o, ifb.iram_rd_addr_o, ifb.inst_valid_o, ifb.inst_data_o,
             ifb.fault_o, ifb.fault_pc_o} !== {1'b0, TopPc, 1'b0, Nop, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL wrap_reset got en=%b addr=%h v=%b d=%h f=%b fpc=%h",
                     ifb.iram_rd_en_o, ifb.iram_rd_addr_o, ifb.inst_valid_o, ifb.inst_data_o,
                     ifb.fault_o, ifb.fault_pc_o);
        end
        rst_b = 1'b1;
        settle();
        total++;
        if ({ifb.iram_rd_en_o, ifb.iram_rd_addr_o, ifb.inst_valid_o} !== {1'b1, TopPc, 1'b0})
        begin
            bad++;
            $display("FAIL wrap_restart got en=%b addr=%h v=%b want en=1 addr=%h v=0",
                     ifb.iram_rd_en_o, ifb.iram_rd_addr_o, ifb.inst_valid_o, TopPc);
        end
    endtask

    initial begin
        rst_a             = 1'b0;
        rst_b             = 1'b0;
        fault_addr        = 32'h1;
        ifa.inst_ready_i  = 1'b0;
        ifa.redirect_en_i = 1'b0;
        ifa.redirect_pc_i = 32'h0;
        ifb.inst_ready_i  = 1'b0;
        ifb.redirect_en_i = 1'b0;
        ifb.redirect_pc_i = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_handshake();
        test_fault();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
